// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement sequencer.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        CAPTURE,
        DONE
    } ro_puf_state_t;

    localparam int CLEAR_CYC = 2;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_puf_window_timer.sv
// Loadable down-counter; expire marks the last cycle of a loaded interval.
module ro_puf_window_timer #(
    parameter int TW = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expire
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - TW'(1);
    end

    assign expire = (cnt == TW'(1));

endmodule

// File: rtl/ro_puf_ctrl.sv
// RO PUF sequencer: per challenge pair clear, count, settle and compare the
// dual edge counter, building resp/tie one bit per pair.
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int N_BITS = 8,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  chal,
    output logic              busy,
    output logic              resp_valid,
    output logic [N_BITS-1:0] resp,
    output logic [N_BITS-1:0] tie,
    output logic [SEL_W-1:0]  ro_sel_a,
    output logic [SEL_W-1:0]  ro_sel_b,
    output logic              cnt_enable,
    output logic              cnt_reset,
    input  logic [CNT_W-1:0]  count1,
    input  logic [CNT_W-1:0]  count2
);

    localparam int TW    = $clog2(imax(WINDOW, SETTLE) + 1);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    ro_puf_state_t    state, next;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             expire, tload;
    logic [TW-1:0]    tload_val;
    logic             busy_d, valid_d, en_d, rst_d;

    assign last = (idx == IDX_W'(N_BITS - 1));

    // One timer serves CLEAR, RUN and SETTLE; it is reloaded on every state entry.
    assign tload = (next != state);

    always_comb begin
        tload_val = '0;
        case (next)
            CLEAR:              tload_val = TW'(CLEAR_CYC);
            RUN:                tload_val = TW'(WINDOW);
            ro_puf_pkg::SETTLE: tload_val = TW'(SETTLE);
            default:            tload_val = '0;
        endcase
    end

    ro_puf_window_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tload),
        .load_val (tload_val),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:               if (start)  next = CLEAR;
            CLEAR:              if (expire) next = RUN;
            RUN:                if (expire) next = ro_puf_pkg::SETTLE;
            ro_puf_pkg::SETTLE: if (expire) next = CAPTURE;
            CAPTURE:            next = last ? DONE : CLEAR;
            DONE:               next = IDLE;
            default:            next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without lagging the state by a cycle.
    always_comb begin
        busy_d  = (next != IDLE);
        valid_d = (next == DONE);
        en_d    = (next == RUN);
        rst_d   = (next == IDLE) || (next == CLEAR) || (next == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            cnt_enable <= 1'b0;
            cnt_reset  <= 1'b1;
        end else begin
            busy       <= busy_d;
            resp_valid <= valid_d;
            cnt_enable <= en_d;
            cnt_reset  <= rst_d;
        end
    end

    // Selects advance by two per pair, so they always equal chal + 2i (mod 2^SEL_W).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            resp     <= '0;
            tie      <= '0;
            ro_sel_a <= '0;
            ro_sel_b <= '0;
        end else if (state == IDLE && start) begin
            idx      <= '0;
            resp     <= '0;
            tie      <= '0;
            ro_sel_a <= chal;
            ro_sel_b <= chal + SEL_W'(1);
        end else if (state == CAPTURE) begin
            resp[idx] <= (count1 > count2);
            tie[idx]  <= (count1 == count2);
            if (!last) begin
                idx      <= idx + IDX_W'(1);
                ro_sel_a <= ro_sel_a + SEL_W'(2);
                ro_sel_b <= ro_sel_b + SEL_W'(2);
            end
        end
    end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Directed bench for ro_puf_ctrl with a behavioural dual-counter and a response scoreboard.
module tb_ro_puf_ctrl;

    localparam int N   = 2;
    localparam int SW  = 4;
    localparam int CW  = 8;
    localparam int W   = 16;
    localparam int S   = 4;
    localparam int P   = 2 + W + S + 1;
    localparam int LAT = N * P + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [SW-1:0] chal;
    logic          busy, resp_valid, cnt_enable, cnt_reset;
    logic [N-1:0]  resp, tie;
    logic [SW-1:0] ro_sel_a, ro_sel_b;
    logic [CW-1:0] c1 = '0, c2 = '0;

    ro_puf_ctrl #(.N_BITS(N), .SEL_W(SW), .CNT_W(CW), .WINDOW(W), .SETTLE(S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .chal       (chal),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp       (resp),
        .tie        (tie),
        .ro_sel_a   (ro_sel_a),
        .ro_sel_b   (ro_sel_b),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .count1     (c1),
        .count2     (c2)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed { logic [N-1:0] resp; logic [N-1:0] tie; } exp_t;
    exp_t exp_q[$];

    // Counter model: zero under reset, ramps while enabled, then presents the
    // final (possibly frozen/saturated) counts for the current pair.
    logic [CW-1:0] t1[4], t2[4];
    logic [1:0]    idx_m = '0;
    logic          rq = 1'b1;
    int            cyc = 0;

    always @(posedge clk) begin
        rq  <= cnt_reset;
        cyc <= cyc + 1;
        if (!busy)
            idx_m <= '0;
        else if (cnt_reset && !rq)
            idx_m <= idx_m + 2'd1;
        if (cnt_reset) begin
            c1 <= '0;
            c2 <= '0;
        end else if (cnt_enable) begin
            c1 <= c1 + 8'd1;
            c2 <= c2 + 8'd1;
        end else begin
            c1 <= t1[idx_m];
            c2 <= t2[idx_m];
        end
    end

    // Protocol monitor: exclusivity, select stability and window length.
    logic [SW-1:0] sa[4], sb[4];
    int run_len = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            run_len <= 0;
        end else begin
            chk("excl", {31'b0, cnt_enable & cnt_reset}, 32'd0);
            if (cnt_enable) begin
                if (run_len == 0) begin
                    sa[idx_m] <= ro_sel_a;
                    sb[idx_m] <= ro_sel_b;
                end else begin
                    chk("sel_stable", 32'({ro_sel_a, ro_sel_b}), 32'({sa[idx_m], sb[idx_m]}));
                end
                run_len <= run_len + 1;
            end else if (run_len != 0) begin
                chk("win_len", run_len, W);
                run_len <= 0;
            end
        end
    end

    task automatic run_txn(input logic [SW-1:0] c,
                           input logic [CW-1:0] a0, b0, a1, b1,
                           input logic [N-1:0] er, et,
                           input logic [SW-1:0] sa0, sb0, sa1, sb1,
                           input bit spur);
        int   k, n;
        bit   seen;
        exp_t e;
        t1[0] = a0; t2[0] = b0; t1[1] = a1; t2[1] = b1; t1[2] = '0; t2[2] = '0;
        exp_q.push_back('{resp: er, tie: et});
        start = 1'b1;
        chal  = c;
        @(negedge clk);
        start = 1'b0;
        chal  = ~c;
        chk("busy_c1", 32'(busy), 32'd1);
        k = 1;
        seen = 1'b0;
        while (k < 200) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            start = (spur && k == 9);
            if (spur && k == 9) chal = '0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("valid_seen", 32'(seen), 32'd1);
        chk("latency", k, LAT);
        chk("busy_at_valid", 32'(busy), 32'd1);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp", 32'(resp), 32'(e.resp));
            chk("tie", 32'(tie), 32'(e.tie));
        end
        chk("sel_p0", 32'({sa[0], sb[0]}), 32'({sa0, sb0}));
        chk("sel_p1", 32'({sa[1], sb[1]}), 32'({sa1, sb1}));
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        n = 0;
        repeat (30) begin
            if (resp_valid) n++;
            @(negedge clk);
        end
        chk("extra_valid", n, 0);
        chk("resp_hold", 32'({resp, tie}), 32'({er, et}));
    endtask

    initial begin
        int  k, n;
        bit  ok;
        reset_n = 1'b0;
        start   = 1'b0;
        chal    = '0;
        for (int i = 0; i < 4; i++) begin
            t1[i] = '0;
            t2[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_tie", 32'({resp, tie}), 32'd0);
        chk("rst_sel", 32'({ro_sel_a, ro_sel_b}), 32'd0);
        chk("rst_cnt_ctl", 32'({cnt_enable, cnt_reset}), 32'b01);
        reset_n = 1'b1;
        @(negedge clk);

        run_txn(4'h3, 8'd20, 8'd15, 8'd10, 8'd10, 2'b01, 2'b10, 4'h3, 4'h4, 4'h5, 4'h6, 1'b0);
        run_txn(4'hF, 8'd1, 8'd2, 8'd3, 8'd3, 2'b00, 2'b10, 4'hF, 4'h0, 4'h1, 4'h2, 1'b0);
        run_txn(4'h0, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 2'b01, 2'b10, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0);
        run_txn(4'h8, 8'd5, 8'd9, 8'd9, 8'd5, 2'b10, 2'b00, 4'h8, 4'h9, 4'hA, 4'hB, 1'b1);

        // Reset during RUN of pair 1 after pair 0 has already set resp[0].
        t1[0] = 8'd20; t2[0] = 8'd15; t1[1] = 8'd10; t2[1] = 8'd10;
        start = 1'b1;
        chal  = 4'h2;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        k  = 0;
        while (k < 200) begin
            if (idx_m == 2'd1 && cnt_enable) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        chk("reach_run1", 32'(ok), 32'd1);
        chk("resp_before_rst", 32'(resp), 32'b01);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt_ctl", 32'({cnt_enable, cnt_reset}), 32'b01);
        chk("mid_rst_resp", 32'({resp, tie}), 32'd0);
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (80) begin
            if (resp_valid) n++;
            @(negedge clk);
        end
        chk("no_valid_after_rst", n, 0);

        run_txn(4'h6, 8'd7, 8'd7, 8'd30, 8'd2, 2'b10, 2'b01, 4'h6, 4'h7, 4'h8, 4'h9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Sequencer for the ring-oscillator PUF measurement path. On a start request it walks through N_BITS oscillator pairs derived from a challenge. For each pair it clears the dual RO edge counter, enables it for a fixed window, waits for the counts to settle, and compares them to produce one response bit. It sits between the challenge/response host interface and the RO mux plus dual-counter datapath, and is the only agent driving that counter's `enable` and `reset`.

## Interface
Parameters:
- `N_BITS`, 8: response bits per challenge, one oscillator pair each.
- `SEL_W`, 4: RO mux select width, giving 2^SEL_W oscillators.
- `CNT_W`, 8: width of each edge counter.
- `WINDOW`, 1024: clk cycles the counter enable is held high per pair (≥1).
- `SETTLE`, 4: clk cycles after enable drops before counts are sampled (≥2; covers RO-domain to clk-domain settling).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `chal` in SEL_W: challenge, latched on accepted start.
- `busy` out 1: high from the cycle after an accepted start until DONE completes.
- `resp_valid` out 1: one-cycle pulse when `resp` is final.
- `resp` out N_BITS: response; bit i = 1 when count1 > count2 for pair i.
- `tie` out N_BITS: bit i = 1 when count1 == count2 for pair i.
- `ro_sel_a`, `ro_sel_b` out SEL_W: selects for the oscillators feeding counter clocks c1 and c2.
- `cnt_enable` out 1: counter enable.
- `cnt_reset` out 1: counter reset, active-high.
- `count1`, `count2` in CNT_W: counter values, sampled only in CAPTURE.

## Operation
- Reset values: state IDLE, busy=0, resp_valid=0, resp=0, tie=0, ro_sel_a=0, ro_sel_b=0, cnt_enable=0, cnt_reset=1, bit index=0, timer=0.
- FSM states: IDLE → CLEAR → RUN → SETTLE → CAPTURE → (CLEAR or DONE) → IDLE.
- IDLE:
  - cnt_reset=1, cnt_enable=0.
  - On start=1: latch chal, clear resp and tie, set bit index=0, go to CLEAR.
- Pair selection for bit index i:
  - ro_sel_a = (chal + 2i) mod 2^SEL_W.
  - ro_sel_b = (chal + 2i + 1) mod 2^SEL_W.
  - Both are registered and updated on entry to CLEAR.
  - Addition wraps at SEL_W bits.
- CLEAR: 2 cycles; cnt_reset=1, cnt_enable=0.
- RUN: WINDOW cycles; cnt_reset=0, cnt_enable=1.
- SETTLE: SETTLE cycles; cnt_enable=0, cnt_reset=0.
- CAPTURE: 1 cycle.
  - resp[i] ← (count1 > count2), tie[i] ← (count1 == count2), both unsigned CNT_W compares.
  - If i == N_BITS-1, go to DONE; otherwise increment i and go to CLEAR.
- DONE: 1 cycle; resp_valid=1, cnt_reset=1. Then go to IDLE.
- resp and tie hold their values until the next accepted start.
- Counter saturation: the counter freezes both counts once either reaches all-ones. The controller needs no special case; the compare result stands, and if both are all-ones the bit is recorded as a tie.
- start while busy is ignored and is not queued.
- reset_n low at any point: immediate return to reset values; a partial response is discarded and no resp_valid is issued.

## Timing
- Per-pair period P = 2 + WINDOW + SETTLE + 1 cycles.
- Counting the cycle after the start-sampling edge as cycle 1:
  - CLEAR of pair 0 occupies cycles 1–2.
  - resp_valid is high in cycle N_BITS·P + 1.
  - busy is high in cycles 1 through N_BITS·P + 1.
- Earliest new start is accepted in cycle N_BITS·P + 2.
- cnt_enable and cnt_reset are never high in the same cycle.
- ro_sel_a and ro_sel_b change only on CLEAR entry, while cnt_reset=1.
- All outputs are registered; none is combinational from inputs.
- Timer width is $clog2(max(WINDOW, SETTLE) + 1). It reloads on each state entry and counts down to 1.

## Structure
- Package `ro_puf_pkg`:
  - state enum `ro_puf_state_t` {IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE}.
  - constant `CLEAR_CYC` = 2.
- Sub-module `ro_puf_window_timer`: loadable down-counter with a `load` value input and an `expire` output. It is shared by CLEAR, RUN and SETTLE.
- The FSM, index counter and compare/capture registers stay in the top level.

## Test plan
Scenarios use WINDOW=16 and SETTLE=4 unless stated (P=23).
- Basic, N_BITS=2: start with chal=4'h3, counter model gives count1=20/count2=15, then 10/10 → resp=2'b01, tie=2'b10, resp_valid in cycle 47, selects (3,4) then (5,6).
- Wrap-around: chal=4'hF, N_BITS=1 → ro_sel_a=4'hF, ro_sel_b=4'h0.
- Saturation: counter model freezes at count1=8'hFF, count2=8'hC0 → resp bit=1, tie=0. With both 8'hFF → resp bit=0, tie=1.
- Start while busy: second start pulse at cycle 10 → ignored, exactly one resp_valid, chal unchanged.
- Mid-operation reset: reset_n low during RUN of pair 1 → next cycle busy=0, cnt_enable=0, cnt_reset=1, resp=0, no resp_valid. A new start then completes normally.
- Protocol checks throughout: cnt_enable and cnt_reset never both high; selects stable while cnt_enable=1; cnt_enable high exactly WINDOW cycles per pair.
